// File: rtl/topo2a_ad_proj_mac_pipe.sv
// Multi-lane pipelined signed x unsigned multiply/accumulate with round-half-up shift,
// output saturation and a single valid/ready handshake shared by all lanes.
module topo2a_ad_proj_mac_pipe #(
  parameter int LANES     = 4,
  parameter int DIN0_W    = 16,
  parameter int DIN1_W    = 8,
  parameter int ACC_W     = 32,
  parameter int DOUT_W    = 23,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_acc,
  input  logic                      in_last,
  input  logic [LANES*DIN0_W-1:0]   din0,
  input  logic [LANES*DIN1_W-1:0]   din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DOUT_W-1:0]   dout,
  output logic [LANES-1:0]          out_sat
);
  localparam int PW = DIN0_W + DIN1_W;
  localparam int D  = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DOUT_W){1'b1}}, {(DOUT_W-1){1'b0}}};

  // Handshake: a beat is taken when in_valid & in_ready, a result leaves when
  // out_valid & out_ready. The whole pipe advances as one when the output slot is
  // free or being drained, so in_ready never looks at in_valid.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  function automatic logic signed [PW-1:0] prod(input logic [DIN0_W-1:0] a,
                                                input logic [DIN1_W-1:0] b);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = PW'($signed(a));
    sb = PW'({1'b0, b});
    return sa * sb;
  endfunction

  logic signed [ACC_W-1:0] p_in [LANES];
  always_comb begin
    for (int i = 0; i < LANES; i++)
      p_in[i] = ACC_W'(prod(din0[i*DIN0_W +: DIN0_W], din1[i*DIN1_W +: DIN1_W]));
  end

  logic                    s1_v;
  logic                    s1_acc;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_p [LANES];

  // With a single stage the product feeds accumulate/round/saturate directly.
  if (NUM_STAGE == 1) begin : g_s1_comb
    always_comb begin
      s1_v    = in_valid & in_ready;
      s1_acc  = in_acc;
      s1_last = in_last;
      for (int i = 0; i < LANES; i++) s1_p[i] = p_in[i];
    end
  end else begin : g_s1_reg
    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        s1_v    <= 1'b0;
        s1_acc  <= 1'b0;
        s1_last <= 1'b0;
        for (int i = 0; i < LANES; i++) s1_p[i] <= '0;
      end else if (adv) begin
        s1_v    <= in_valid;
        s1_acc  <= in_acc;
        s1_last <= in_last;
        for (int i = 0; i < LANES; i++) s1_p[i] <= p_in[i];
      end
    end
  end

  // The accumulator is zero whenever no group is open, so "open ? acc : 0" is just acc.
  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] acc_sum [LANES];
  logic signed [ACC_W-1:0] vsel    [LANES];
  logic signed [ACC_W:0]   ext     [LANES];
  logic signed [ACC_W:0]   rr      [LANES];
  logic                    st_v;
  logic [LANES*DOUT_W-1:0] st_d;
  logic [LANES-1:0]        st_s;

  always_comb begin
    st_v = s1_v & (!s1_acc | s1_last);
    st_d = '0;
    st_s = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_sum[i] = acc[i] + s1_p[i];
      vsel[i]    = s1_acc ? acc_sum[i] : s1_p[i];
      ext[i]     = $signed({vsel[i][ACC_W-1], vsel[i]}) + RND;
      rr[i]      = ext[i] >>> SHIFT;
      if (rr[i] > MAXV) begin
        st_d[i*DOUT_W +: DOUT_W] = MAXV[DOUT_W-1:0];
        st_s[i]                  = 1'b1;
      end else if (rr[i] < MINV) begin
        st_d[i*DOUT_W +: DOUT_W] = MINV[DOUT_W-1:0];
        st_s[i]                  = 1'b1;
      end else begin
        st_d[i*DOUT_W +: DOUT_W] = rr[i][DOUT_W-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (s1_v && adv && s1_acc) begin
      for (int i = 0; i < LANES; i++) acc[i] <= s1_last ? '0 : acc_sum[i];
    end
  end

  logic [D-1:0]            ch_v;
  logic [LANES*DOUT_W-1:0] ch_d [D];
  logic [LANES-1:0]        ch_s [D];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ch_v <= '0;
      for (int k = 0; k < D; k++) begin
        ch_d[k] <= '0;
        ch_s[k] <= '0;
      end
    end else if (adv) begin
      ch_v[0] <= st_v;
      ch_d[0] <= st_d;
      ch_s[0] <= st_s;
      for (int k = 1; k < D; k++) begin
        ch_v[k] <= ch_v[k-1];
        ch_d[k] <= ch_d[k-1];
        ch_s[k] <= ch_s[k-1];
      end
    end
  end

  assign out_valid = ch_v[D-1];
  assign dout      = ch_d[D-1];
  assign out_sat   = ch_s[D-1];
endmodule
